fpu_shift_pipe: RTL and testbench
=================================

Name: fpu_shift_pipe

Overview:
Pipelined, runtime-configurable mantissa shifter for the FPU datapath. It is the successor to the fixed-direction combinational shifter. It supports right-align with guard/round/sticky generation, plain left shift with overflow detection, and leading-zero normalisation. It sits between exponent compare and the adder, and between the adder and the rounder, with valid/ready handshakes on both sides.

Parameters:
N_mant, 24, mantissa width in bits (>=4)
N_exp, 8, shift-amount width; must satisfy 2^N_exp > N_mant+2
TAG_W, 4, width of opaque sideband tag carried with each operation

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation offered
in_ready  output  1  operation accepted when in_valid&in_ready
in_mode  input  2  00 right-align, 01 left, 10 normalise, 11 pass-through
in_data  input  N_mant  mantissa
in_shamt  input  N_exp  shift amount (ignored in modes 10/11)
in_tag  input  TAG_W  sideband, returned unchanged
out_valid  output  1  result available
out_ready  input  1  downstream accepts when out_valid&out_ready
out_data  output  N_mant  shifted mantissa
out_grs  output  3  {guard, round, sticky}; zero except mode 00
out_shamt  output  N_exp  amount actually applied
out_zero  output  1  out_data==0
out_ovf  output  1  mode 01 only: a 1 bit was shifted out
out_tag  output  TAG_W  tag of this result

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset state: all pipeline valid flags 0, all data/flag/tag registers 0, so every output reads 0. in_ready is 1 in the first cycle after reset deassertion.
- Pipeline: two registered stages, S1 and S2. Latency is exactly 2 cycles from acceptance to out_valid with no backpressure. Throughput is one operation per cycle.
- S1 registers the input and computes the effective amount:
  - mode 00: in_shamt, saturated to N_mant+2.
  - mode 01: in_shamt, saturated to N_mant.
  - mode 10: lzc(in_data); equals N_mant when in_data==0.
  - mode 11: 0.
- S2 performs the shift on an extended N_mant+2 datapath and registers all outputs.
- Mode 00:
  - {out_data, guard, round} = ({in_data, 2'b00} >> amt).
  - sticky = OR of every bit shifted below round.
  - amt >= N_mant+2 gives out_data=0, guard=round=0, sticky=|in_data.
- Mode 01:
  - out_data = in_data << amt.
  - out_ovf = OR of the bits shifted out.
  - amt >= N_mant gives 0, with ovf=|in_data.
- Mode 10:
  - out_data = in_data << lzc; out_shamt = lzc.
  - zero input gives out_data=0, out_zero=1, out_shamt=N_mant.
- Stall and pipeline rules:
  - Each stage advances when the next stage is empty or advancing. S2 advances on !out_valid | out_ready.
  - in_ready = !S1_valid | S1_advance (combinational from out_ready; no skid buffer).
  - Outputs hold stable while out_valid & !out_ready.
  - Results are never dropped or duplicated; order is preserved.
- Simultaneous events: accept and emit in the same cycle is legal with the pipeline full and out_ready=1.
- Reset mid-operation: in-flight operations are discarded, outputs return to 0 immediately (asynchronous), and no partial result appears after release.
- Width rule: out_shamt is the saturated value, never the raw in_shamt.

Decomposition:
- Package fpu_shift_pkg holds:
  - mode encoding constants MODE_RALIGN, MODE_LEFT, MODE_NORM, MODE_PASS;
  - GRS bit-index constants;
  - a function giving the saturation limit per mode.
- One sub-module, fpu_lzc: a parametrised combinational leading-zero counter (width N_mant, output N_exp, N_mant on all-zero input), instantiated in S1.

Test Plan:
- Right-align: mode 00, data 0x800001, shamt 2 -> 2 cycles later out_data=0x200000, grs=3'b010, ovf=0, shamt=2.
- Right-align saturation: mode 00, data 0x000001, shamt 30 -> out_data=0, grs=3'b001, shamt=26, zero=1.
- Left overflow: mode 01, data 0xC00000, shamt 1 -> out_data=0x800000, ovf=1. Then data 0x400000, shamt 1 -> 0x800000, ovf=0.
- Normalise: mode 10, data 0x00F000 -> 0xF00000, shamt=8. Then data 0 -> out_data=0, zero=1, shamt=24.
- Backpressure: hold out_ready=0 and offer 3 back-to-back ops with tags 1, 2, 3.
  - Required: 2 accepted, then in_ready=0; outputs stable.
  - On release: tags emerge 1, 2, 3 on consecutive cycles with correct data.
- Reset mid-flight: assert rst_n=0 with 2 ops in flight -> out_valid=0 and outputs 0 immediately. After release, in_ready=1 and no stale result ever appears.

Source files
------------

// File: rtl/fpu_shift_pkg.sv
// Shared definitions for the pipelined mantissa shifter: operation modes,
// guard/round/sticky bit positions and the per-mode shift saturation limit.
package fpu_shift_pkg;

    typedef enum logic [1:0] {
        MODE_RALIGN = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_NORM   = 2'b10,
        MODE_PASS   = 2'b11
    } mode_e;

    localparam int unsigned GRS_W      = 3;
    localparam int unsigned GRS_GUARD  = 2;
    localparam int unsigned GRS_ROUND  = 1;
    localparam int unsigned GRS_STICKY = 0;

    // Largest shift amount that still changes the result for a given mode.
    function automatic int unsigned sat_limit(input mode_e mode, input int unsigned n_mant);
        case (mode)
            MODE_RALIGN: return n_mant + 2;
            MODE_LEFT:   return n_mant;
            MODE_NORM:   return n_mant;
            default:     return 0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; reports WIDTH for an all-zero input.
module fpu_lzc #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned CNT_W = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    logic found;

    // Scan from the MSB down; the first set bit fixes the count.
    always_comb begin
        count = CNT_W'(WIDTH);
        found = 1'b0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (!found && data[WIDTH-1-k]) begin
                count = CNT_W'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_shift_pipe.sv
// Two-stage runtime-configurable mantissa shifter with valid/ready on both
// sides. S1 captures the operand and resolves the effective shift amount;
// S2 performs the shift on an N_mant+2 datapath and holds the result.
module fpu_shift_pipe
    import fpu_shift_pkg::*;
#(
    parameter int unsigned N_mant = 24,
    parameter int unsigned N_exp  = 8,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [N_mant-1:0] in_data,
    input  logic [N_exp-1:0]  in_shamt,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_mant-1:0] out_data,
    output logic [2:0]        out_grs,
    output logic [N_exp-1:0]  out_shamt,
    output logic              out_zero,
    output logic              out_ovf,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int unsigned W = N_mant + 2;

    logic              s1_valid;
    mode_e             s1_mode;
    logic [N_mant-1:0] s1_data;
    logic [N_exp-1:0]  s1_amt;
    logic [TAG_W-1:0]  s1_tag;

    logic              s2_adv;
    mode_e             mode_in;
    logic [N_exp-1:0]  lzc_cnt;
    logic [N_exp-1:0]  lim;
    logic [N_exp-1:0]  amt_next;

    logic [W-1:0]        ext;
    logic [W-1:0]        shr;
    logic [W-1:0]        ones;
    logic [W-1:0]        below;
    logic [2*N_mant-1:0] wide;
    logic [N_mant-1:0]   res_data;
    logic [GRS_W-1:0]    res_grs;
    logic                res_ovf;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign mode_in  = mode_e'(in_mode);

    fpu_lzc #(.WIDTH(N_mant), .CNT_W(N_exp)) u_lzc (
        .data  (in_data),
        .count (lzc_cnt)
    );

    // Effective shift amount: saturated request, leading-zero count, or zero.
    always_comb begin
        lim      = N_exp'(sat_limit(mode_in, N_mant));
        amt_next = '0;
        case (mode_in)
            MODE_RALIGN, MODE_LEFT: amt_next = (in_shamt > lim) ? lim : in_shamt;
            MODE_NORM:              amt_next = lzc_cnt;
            default:                amt_next = '0;
        endcase
    end

    // S1 register: loads whenever it is empty or handing its operand to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_RALIGN;
            s1_data  <= '0;
            s1_amt   <= '0;
            s1_tag   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= mode_in;
                s1_data <= in_data;
                s1_amt  <= amt_next;
                s1_tag  <= in_tag;
            end
        end
    end

    // Shift datapath; amounts are pre-saturated so every shift stays in range.
    always_comb begin
        ext      = {s1_data, 2'b00};
        shr      = ext >> s1_amt;
        ones     = '1;
        below    = ext & ~(ones << s1_amt);
        wide     = {{N_mant{1'b0}}, s1_data} << s1_amt;
        res_data = s1_data;
        res_grs  = '0;
        res_ovf  = 1'b0;
        case (s1_mode)
            MODE_RALIGN: begin
                res_data             = shr[W-1:2];
                res_grs[GRS_GUARD]   = shr[1];
                res_grs[GRS_ROUND]   = shr[0];
                res_grs[GRS_STICKY]  = |below;
            end
            MODE_LEFT: begin
                res_data = wide[N_mant-1:0];
                res_ovf  = |wide[2*N_mant-1:N_mant];
            end
            MODE_NORM: res_data = s1_data << s1_amt;
            default:   res_data = s1_data;
        endcase
    end

    // S2 register: drives the outputs directly and holds them while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grs   <= '0;
            out_shamt <= '0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
            out_tag   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data  <= res_data;
                out_grs   <= res_grs;
                out_shamt <= s1_amt;
                out_zero  <= (res_data == '0);
                out_ovf   <= res_ovf;
                out_tag   <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_fpu_shift_pipe.sv
// Self-checking bench for fpu_shift_pipe: directed cases from the shifter's
// behaviour, backpressure and mid-flight reset, then randomized traffic
// checked every cycle against an arithmetic reference model and queue.
module tb_fpu_shift_pipe;

    localparam int unsigned NM = 24;
    localparam int unsigned NE = 8;
    localparam int unsigned TW = 4;

    typedef struct {
        logic [NM-1:0] data;
        logic [2:0]    grs;
        logic [NE-1:0] shamt;
        logic          zero;
        logic          ovf;
        logic [TW-1:0] tag;
        int unsigned   acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [NM-1:0] in_data;
    logic [NE-1:0] in_shamt;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [NM-1:0] out_data;
    logic [2:0]    out_grs;
    logic [NE-1:0] out_shamt;
    logic          out_zero;
    logic          out_ovf;
    logic [TW-1:0] out_tag;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    exp_t        q[$];

    fpu_shift_pipe #(.N_mant(NM), .N_exp(NE), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_grs   (out_grs),
        .out_shamt (out_shamt),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: what each mode must produce, from plain 64-bit arithmetic.
    function automatic exp_t model(input logic [1:0] m, input logic [NM-1:0] d,
                                   input logic [NE-1:0] s, input logic [TW-1:0] t);
        exp_t e;
        longint unsigned dd, sv, a, ext, res, w, mask;
        e.data = '0; e.grs = '0; e.shamt = '0; e.zero = 1'b0; e.ovf = 1'b0;
        e.tag = t; e.acc = 0;
        dd   = 64'(d);
        sv   = 64'(s);
        mask = (64'd1 << NM) - 1;
        case (m)
            2'b00: begin
                a      = (sv > NM + 2) ? 64'(NM + 2) : sv;
                ext    = dd << 2;
                res    = ext >> a;
                e.data = NM'(res >> 2);
                e.grs  = {res[1], res[0], (ext & ((64'd1 << a) - 1)) != 0};
                e.shamt = NE'(a);
            end
            2'b01: begin
                a      = (sv > NM) ? 64'(NM) : sv;
                w      = dd << a;
                e.data = NM'(w & mask);
                e.ovf  = (w >> NM) != 0;
                e.shamt = NE'(a);
            end
            2'b10: begin
                a = 64'(NM);
                for (int i = 0; i < int'(NM); i++)
                    if (dd[i]) a = 64'(NM - 1 - i);
                e.data  = NM'((dd << a) & mask);
                e.shamt = NE'(a);
            end
            default: e.data = d;
        endcase
        e.zero = (e.data == '0);
        return e;
    endfunction

    // Per-cycle checker: occupancy-based valid/ready, ordered results, holds.
    logic          hold_v = 1'b0;
    logic [NM-1:0] hold_data;
    logic [TW-1:0] hold_tag;
    logic [NE-1:0] hold_shamt;
    logic [2:0]    hold_grs;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            logic exp_valid;
            exp_t e;
            exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 2);
            check("mon_out_valid", out_valid, exp_valid);
            check("mon_in_ready", in_ready, (q.size() < 2) || out_ready);
            if (hold_v && out_valid) begin
                check("hold_data", out_data, hold_data);
                check("hold_tag", out_tag, hold_tag);
                check("hold_shamt", out_shamt, hold_shamt);
                check("hold_grs", out_grs, hold_grs);
            end
            if (out_valid && exp_valid) begin
                e = q[0];
                check("mon_data", out_data, e.data);
                check("mon_grs", out_grs, e.grs);
                check("mon_shamt", out_shamt, e.shamt);
                check("mon_zero", out_zero, e.zero);
                check("mon_ovf", out_ovf, e.ovf);
                check("mon_tag", out_tag, e.tag);
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                e = model(in_mode, in_data, in_shamt, in_tag);
                e.acc = cyc;
                q.push_back(e);
            end
            hold_v     = out_valid && !out_ready;
            hold_data  = out_data;
            hold_tag   = out_tag;
            hold_shamt = out_shamt;
            hold_grs   = out_grs;
        end
    end

    task automatic run_one(input logic [1:0] m, input logic [NM-1:0] d, input logic [NE-1:0] s,
                           input logic [TW-1:0] t, input logic [NM-1:0] ed, input logic [2:0] eg,
                           input logic [NE-1:0] es, input logic ez, input logic eo);
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1;
        in_mode = m; in_data = d; in_shamt = s; in_tag = t;
        @(negedge clk);
        check("dir_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("dir_not_early", out_valid, 0);
        @(negedge clk);
        check("dir_valid", out_valid, 1);
        check("dir_data", out_data, ed);
        check("dir_grs", out_grs, eg);
        check("dir_shamt", out_shamt, es);
        check("dir_zero", out_zero, ez);
        check("dir_ovf", out_ovf, eo);
        check("dir_tag", out_tag, t);
    endtask

    task automatic drive(input logic [1:0] m, input logic [NM-1:0] d, input logic [NE-1:0] s,
                         input logic [TW-1:0] t);
        in_valid = 1'b1; in_mode = m; in_data = d; in_shamt = s; in_tag = t;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t pe;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mode = '0; in_data = '0; in_shamt = '0; in_tag = '0;

        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_grs", out_grs, 0);
        check("rst_out_shamt", out_shamt, 0);
        check("rst_out_flags", {out_zero, out_ovf}, 0);
        check("rst_out_tag", out_tag, 0);
        #9 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Literal expectations pinning the reference model.
        pe = model(2'b00, 24'h800001, 8'd2, 4'd0);
        check("pin_ralign", {pe.data, pe.grs, pe.shamt}, {24'h200000, 3'b010, 8'd2});
        pe = model(2'b00, 24'h000001, 8'd30, 4'd0);
        check("pin_ralign_sat", {pe.data, pe.grs, pe.shamt, pe.zero}, {24'h0, 3'b001, 8'd26, 1'b1});
        pe = model(2'b01, 24'hC00000, 8'd1, 4'd0);
        check("pin_left_ovf", {pe.data, pe.ovf}, {24'h800000, 1'b1});
        pe = model(2'b10, 24'h00F000, 8'd0, 4'd0);
        check("pin_norm", {pe.data, pe.shamt}, {24'hF00000, 8'd8});
        pe = model(2'b10, 24'h000000, 8'd5, 4'd0);
        check("pin_norm_zero", {pe.data, pe.shamt, pe.zero}, {24'h0, 8'd24, 1'b1});

        // Directed cases.
        run_one(2'b00, 24'h800001, 8'd2,   4'd1, 24'h200000, 3'b010, 8'd2,  1'b0, 1'b0);
        run_one(2'b00, 24'h000001, 8'd30,  4'd2, 24'h000000, 3'b001, 8'd26, 1'b1, 1'b0);
        run_one(2'b01, 24'hC00000, 8'd1,   4'd3, 24'h800000, 3'b000, 8'd1,  1'b0, 1'b1);
        run_one(2'b01, 24'h400000, 8'd1,   4'd4, 24'h800000, 3'b000, 8'd1,  1'b0, 1'b0);
        run_one(2'b01, 24'h000003, 8'd200, 4'd5, 24'h000000, 3'b000, 8'd24, 1'b1, 1'b1);
        run_one(2'b10, 24'h00F000, 8'd77,  4'd6, 24'hF00000, 3'b000, 8'd8,  1'b0, 1'b0);
        run_one(2'b10, 24'h000000, 8'd3,   4'd7, 24'h000000, 3'b000, 8'd24, 1'b1, 1'b0);
        run_one(2'b11, 24'hABCDEF, 8'd9,   4'd8, 24'hABCDEF, 3'b000, 8'd0,  1'b0, 1'b0);

        // Backpressure: two accepted, third refused until release, order kept.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(2'b11, 24'h111111, 8'd0, 4'd1);
        @(negedge clk);
        check("bp_ready_1", in_ready, 1);
        @(posedge clk); #1;
        drive(2'b11, 24'h222222, 8'd0, 4'd2);
        @(negedge clk);
        check("bp_ready_2", in_ready, 1);
        @(posedge clk); #1;
        drive(2'b11, 24'h333333, 8'd0, 4'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_ready_full", in_ready, 0);
            check("bp_stall_tag", out_tag, 1);
            check("bp_stall_data", out_data, 24'h111111);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_tag1", {out_valid, out_tag}, {1'b1, 4'd1});
        check("bp_rel_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_rel_tag2", {out_valid, out_tag, out_data}, {1'b1, 4'd2, 24'h222222});
        @(negedge clk);
        check("bp_rel_tag3", {out_valid, out_tag, out_data}, {1'b1, 4'd3, 24'h333333});
        @(negedge clk);
        check("bp_rel_empty", out_valid, 0);

        // Reset with two operations in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(2'b01, 24'hFFFFFF, 8'd3, 4'd5);
        @(posedge clk); #1;
        drive(2'b00, 24'h00FF00, 8'd4, 4'd6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_tag", out_tag, 0);
        check("mid_rst_shamt", out_shamt, 0);
        check("mid_rst_ovf", out_ovf, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mid_rst_no_stale", out_valid, 0);
        end

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 3000; k++) begin
            logic [NM-1:0] d;
            logic [NE-1:0] s;
            @(posedge clk); #1;
            case ($urandom % 4)
                0:       d = NM'($urandom);
                1:       d = NM'($urandom) >> $urandom_range(0, NM);
                2:       d = '0;
                default: d = NM'(1) << $urandom_range(0, NM - 1);
            endcase
            s = (($urandom % 4) == 0) ? NE'($urandom) : NE'($urandom_range(0, 30));
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            in_mode   = 2'($urandom);
            in_data   = d;
            in_shamt  = s;
            in_tag    = TW'($urandom);
        end

        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("drain_empty", q.size(), 0);
        check("drain_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
